// File: rtl/sobel_gradient_calc.sv
// rtl/sobel_gradient_calc.sv - Sobel gradient stage: Gx, Gy, L1 magnitude and threshold over a 3x3 window
//
// Ports:
//   clk               system clock, rising edge
//   n_rst             asynchronous active-low reset
//   start_calculation one-cycle start pulse, accepted only while idle
//   window            pixels p0..p8 row-major, p0 in the low slice
//   threshold         edge threshold, latched with the window
//   busy              high while a calculation is in progress
//   calculation_done  one-cycle pulse when the outputs below are updated
//   magnitude         |Gx| + |Gy|
//   pixel_out         magnitude saturated to the pixel range
//   edge_out          all-ones when magnitude >= threshold, else zero
module sobel_gradient_calc #(
    parameter int PIXEL_W = 8,
    parameter int MAG_W   = PIXEL_W + 3
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start_calculation,
    input  logic [9*PIXEL_W-1:0] window,
    input  logic [MAG_W-1:0]     threshold,
    output logic                 busy,
    output logic                 calculation_done,
    output logic [MAG_W-1:0]     magnitude,
    output logic [PIXEL_W-1:0]   pixel_out,
    output logic [PIXEL_W-1:0]   edge_out
);

    localparam logic [MAG_W-1:0] PIX_MAX = MAG_W'((1 << PIXEL_W) - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC_X = 2'd1,
        CALC_Y = 2'd2,
        MAG    = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic ld_win;
    logic ld_gx;
    logic ld_gy;
    logic ld_mag;

    logic [9*PIXEL_W-1:0] win_q;
    logic [MAG_W-1:0]     thr_q;
    logic [MAG_W-1:0]     gx_q;
    logic [MAG_W-1:0]     gy_q;

    logic [MAG_W-1:0]     px [9];
    logic [MAG_W-1:0]     gx_d;
    logic [MAG_W-1:0]     gy_d;
    logic [MAG_W-1:0]     abs_gx;
    logic [MAG_W-1:0]     abs_gy;
    logic [MAG_W-1:0]     sum;
    logic [PIXEL_W-1:0]   pix_d;
    logic [PIXEL_W-1:0]   edge_d;

    always_comb begin
        state_d = state_q;
        ld_win  = 1'b0;
        ld_gx   = 1'b0;
        ld_gy   = 1'b0;
        ld_mag  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_calculation) begin
                    ld_win  = 1'b1;
                    state_d = CALC_X;
                end
            end
            CALC_X: begin
                ld_gx   = 1'b1;
                state_d = CALC_Y;
            end
            CALC_Y: begin
                ld_gy   = 1'b1;
                state_d = MAG;
            end
            MAG: begin
                ld_mag  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pixels are zero-extended to MAG_W so the differences below wrap into
    // correct two's complement values without any sign handling.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            px[i] = MAG_W'(win_q[i*PIXEL_W +: PIXEL_W]);
        end
        gx_d   = (px[2] + (px[5] << 1) + px[8]) - (px[0] + (px[3] << 1) + px[6]);
        gy_d   = (px[6] + (px[7] << 1) + px[8]) - (px[0] + (px[1] << 1) + px[2]);
        abs_gx = gx_q[MAG_W-1] ? (MAG_W'(0) - gx_q) : gx_q;
        abs_gy = gy_q[MAG_W-1] ? (MAG_W'(0) - gy_q) : gy_q;
        sum    = abs_gx + abs_gy;
        pix_d  = (sum > PIX_MAX) ? {PIXEL_W{1'b1}} : sum[PIXEL_W-1:0];
        edge_d = (sum >= thr_q) ? {PIXEL_W{1'b1}} : {PIXEL_W{1'b0}};
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q          <= IDLE;
            busy             <= 1'b0;
            calculation_done <= 1'b0;
            win_q            <= '0;
            thr_q            <= '0;
            gx_q             <= '0;
            gy_q             <= '0;
            magnitude        <= '0;
            pixel_out        <= '0;
            edge_out         <= '0;
        end else begin
            state_q          <= state_d;
            busy             <= (state_d != IDLE);
            calculation_done <= ld_mag;
            if (ld_win) begin
                win_q <= window;
                thr_q <= threshold;
            end
            if (ld_gx) begin
                gx_q <= gx_d;
            end
            if (ld_gy) begin
                gy_q <= gy_d;
            end
            if (ld_mag) begin
                magnitude <= sum;
                pixel_out <= pix_d;
                edge_out  <= edge_d;
            end
        end
    end

endmodule

// File: tb/tb_sobel_gradient_calc.sv
// tb/tb_sobel_gradient_calc.sv - directed self-checking bench for sobel_gradient_calc
module tb_sobel_gradient_calc;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start_calculation;
    logic [71:0] window;
    logic [10:0] threshold;
    logic        busy;
    logic        calculation_done;
    logic [10:0] magnitude;
    logic [7:0]  pixel_out;
    logic [7:0]  edge_out;

    int checks = 0;
    int errors = 0;

    logic [71:0] w_flat;
    logic [71:0] w_vert;
    logic [71:0] w_mirr;
    logic [71:0] w_diag;
    logic [71:0] w_small_x;
    logic [71:0] w_neg_y;

    sobel_gradient_calc dut (
        .clk               (clk),
        .n_rst             (n_rst),
        .start_calculation (start_calculation),
        .window            (window),
        .threshold         (threshold),
        .busy              (busy),
        .calculation_done  (calculation_done),
        .magnitude         (magnitude),
        .pixel_out         (pixel_out),
        .edge_out          (edge_out)
    );

    always #5 clk = ~clk;

    function automatic logic [71:0] mk(input logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7, p8);
        return {p8, p7, p6, p5, p4, p3, p2, p1, p0};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [71:0] w, input logic [10:0] thr);
        window            = w;
        threshold         = thr;
        start_calculation = 1'b1;
        tick();
        start_calculation = 1'b0;
    endtask

    // Called right after the start edge; checks the two busy cycles and the result edge.
    task automatic await_result(input string tag, input logic [10:0] mag,
                                input logic [7:0] pix, input logic [7:0] edg);
        chk({tag, "_busy_k"}, 16'(busy), 16'd1);
        chk({tag, "_done_k"}, 16'(calculation_done), 16'd0);
        tick();
        chk({tag, "_done_k1"}, 16'(calculation_done), 16'd0);
        tick();
        chk({tag, "_busy_k2"}, 16'(busy), 16'd1);
        chk({tag, "_done_k2"}, 16'(calculation_done), 16'd0);
        tick();
        chk({tag, "_done_k3"}, 16'(calculation_done), 16'd1);
        chk({tag, "_busy_k3"}, 16'(busy), 16'd0);
        chk({tag, "_mag"}, 16'(magnitude), 16'(mag));
        chk({tag, "_pix"}, 16'(pixel_out), 16'(pix));
        chk({tag, "_edge"}, 16'(edge_out), 16'(edg));
    endtask

    task automatic idle_tick(input string tag);
        tick();
        chk({tag, "_done_low"}, 16'(calculation_done), 16'd0);
        chk({tag, "_busy_low"}, 16'(busy), 16'd0);
    endtask

    initial begin
        w_flat    = mk(100, 100, 100, 100, 100, 100, 100, 100, 100);
        w_vert    = mk(0, 128, 255, 0, 128, 255, 0, 128, 255);
        w_mirr    = mk(255, 128, 0, 255, 128, 0, 255, 128, 0);
        w_diag    = mk(0, 0, 255, 0, 255, 255, 255, 255, 255);
        w_small_x = mk(0, 0, 0, 0, 0, 10, 0, 0, 0);
        w_neg_y   = mk(0, 50, 0, 0, 0, 0, 0, 0, 0);

        n_rst             = 1'b0;
        start_calculation = 1'b0;
        window            = '0;
        threshold         = '0;
        repeat (3) tick();
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(calculation_done), 16'd0);
        chk("rst_mag", 16'(magnitude), 16'd0);
        chk("rst_pix", 16'(pixel_out), 16'd0);
        chk("rst_edge", 16'(edge_out), 16'd0);
        n_rst = 1'b1;
        for (int i = 0; i < 20; i++) idle_tick("idle");

        // Flat window: no gradient at all
        issue(w_flat, 11'd100);
        await_result("flat", 11'd0, 8'd0, 8'd0);
        idle_tick("flat_after");

        // Vertical edge and its mirror
        issue(w_vert, 11'd100);
        await_result("vert", 11'd1020, 8'd255, 8'd255);
        idle_tick("vert_after");
        issue(w_mirr, 11'd100);
        await_result("mirr", 11'd1020, 8'd255, 8'd255);
        idle_tick("mirr_after");

        // Diagonal, threshold exactly at and just above the magnitude
        issue(w_diag, 11'd1530);
        await_result("diag_eq", 11'd1530, 8'd255, 8'd255);
        idle_tick("diag_eq_after");
        issue(w_diag, 11'd1531);
        await_result("diag_gt", 11'd1530, 8'd255, 8'd0);
        idle_tick("diag_gt_after");

        // Unsaturated magnitudes, threshold 0 and out-of-range threshold
        issue(w_small_x, 11'd0);
        await_result("small_thr0", 11'd20, 8'd20, 8'd255);
        idle_tick("small_after");
        issue(w_neg_y, 11'd2047);
        await_result("negy_thrmax", 11'd100, 8'd100, 8'd0);
        idle_tick("negy_after");
        issue(w_flat, 11'd0);
        await_result("flat_thr0", 11'd0, 8'd0, 8'd255);
        idle_tick("flat_thr0_after");

        // Start held and window changed while busy: ignored, latched window used
        issue(w_diag, 11'd100);
        start_calculation = 1'b1;
        window            = w_flat;
        threshold         = 11'd2047;
        chk("ign_busy_k", 16'(busy), 16'd1);
        tick();
        chk("ign_done_k1", 16'(calculation_done), 16'd0);
        tick();
        chk("ign_done_k2", 16'(calculation_done), 16'd0);
        tick();
        start_calculation = 1'b0;
        chk("ign_done_k3", 16'(calculation_done), 16'd1);
        chk("ign_mag", 16'(magnitude), 16'd1530);
        chk("ign_edge", 16'(edge_out), 16'd255);
        idle_tick("ign_after");

        // Start in the done cycle: second done exactly 4 cycles later
        issue(w_vert, 11'd100);
        await_result("b2b_a", 11'd1020, 8'd255, 8'd255);
        issue(w_small_x, 11'd1000);
        await_result("b2b_b", 11'd20, 8'd20, 8'd0);
        idle_tick("b2b_after");

        // Reset while in CALC_Y: outputs cleared, no done pulse
        issue(w_diag, 11'd100);
        tick();
        n_rst = 1'b0;
        #2;
        chk("mid_rst_busy", 16'(busy), 16'd0);
        chk("mid_rst_mag", 16'(magnitude), 16'd0);
        chk("mid_rst_pix", 16'(pixel_out), 16'd0);
        chk("mid_rst_edge", 16'(edge_out), 16'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_rst_done", 16'(calculation_done), 16'd0);
        end
        n_rst = 1'b1;
        for (int i = 0; i < 3; i++) idle_tick("post_rst");

        issue(w_diag, 11'd100);
        await_result("post_rst_diag", 11'd1530, 8'd255, 8'd255);
        idle_tick("post_rst_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sobel_gradient_calc.md
Name: sobel_gradient_calc

Overview:
Gradient stage of the Sobel edge detector. It is triggered by the controller's start_calculation pulse and consumes the 3x3 pixel window assembled by the read stage. It computes Gx, Gy and the L1 magnitude |Gx|+|Gy| over a fixed multi-cycle FSM, then thresholds the magnitude. It returns calculation_done together with the result pixel, which the write stage consumes.

Parameters:
PIXEL_W, 8, width of one grayscale pixel.
MAG_W, PIXEL_W+3, width of the gradient magnitude and threshold (11 at default; holds max 2040).

Ports:
clk  input  1  system clock, rising edge.
n_rst  input  1  asynchronous active-low reset.
start_calculation  input  1  one-cycle start pulse from controller.
window  input  9*PIXEL_W  pixels p0..p8, row-major; p0 = bits [PIXEL_W-1:0], p8 = top slice.
threshold  input  MAG_W  edge threshold; sampled together with window.
busy  output  1  high while a calculation is in progress (state != IDLE).
calculation_done  output  1  one-cycle pulse when results are valid.
magnitude  output  MAG_W  |Gx|+|Gy|, unsigned.
pixel_out  output  PIXEL_W  magnitude saturated to 2^PIXEL_W-1.
edge_out  output  PIXEL_W  all-ones if magnitude >= threshold, else 0.

Behaviour:
- Reset (async, n_rst=0): state=IDLE, busy=0, calculation_done=0, magnitude=0, pixel_out=0, edge_out=0. All internal window, threshold, gx and gy registers are also cleared.
- FSM states: IDLE -> CALC_X -> CALC_Y -> MAG -> IDLE. No other states. Any unreachable encoding recovers to IDLE.
- Edge k, IDLE with start_calculation=1:
  - latch window and threshold;
  - go to CALC_X.
- Edge k+1, CALC_X: gx_reg <= (p2 + 2*p5 + p8) - (p0 + 2*p3 + p6); go to CALC_Y.
- Edge k+2, CALC_Y: gy_reg <= (p6 + 2*p7 + p8) - (p0 + 2*p1 + p2); go to MAG.
- Edge k+3, MAG:
  - magnitude <= |gx_reg| + |gy_reg|;
  - pixel_out <= min(that sum, 2^PIXEL_W-1);
  - edge_out <= all-ones if sum >= threshold_reg, else 0;
  - calculation_done <= 1;
  - go to IDLE.
- Edge k+4: calculation_done <= 0 unless a new result completes on that edge (it cannot, since minimum spacing is 4 cycles).
- Latency: 3 edges from start sample to result. calculation_done is high for exactly one cycle, after edge k+3.
- busy is a registered output: high after edges k, k+1 and k+2; low after edge k+3.
- magnitude, pixel_out and edge_out hold their value until the next completion or reset.
- Arithmetic: gx and gy are MAG_W-bit two's complement (range ±1020 at default; no overflow). Absolute values are MAG_W-bit unsigned. The sum is max 2040 and fits in MAG_W with no wrap.
- Window and threshold are used only from the latched copies. Input changes while busy have no effect on the current result.
- start_calculation while busy=1 is ignored: no restart, no queueing.
- start_calculation in the same cycle calculation_done is high is accepted, because the FSM is already IDLE. Back-to-back throughput is one result per 4 cycles.
- start_calculation held high continuously: a new calculation starts on every IDLE cycle, so done pulses every 4 cycles.
- Reset mid-operation: immediate return to the reset values. No calculation_done is produced for the aborted operation.
- threshold = 0: every result yields edge_out all-ones. threshold > 2040: edge_out is always 0.

Test Plan:
- Reset then idle: n_rst low mid-run -> all outputs 0, busy 0. With no start there is no done pulse for 20 cycles.
- Flat window, all p=100, threshold=100 -> gx=0, gy=0, magnitude=0, pixel_out=0, edge_out=0. done is high exactly 3 edges after the start sample, for 1 cycle.
- Vertical edge: left column 0, right column 255, middle column 128, threshold=100 -> gx=1020, gy=0, magnitude=1020, pixel_out=255, edge_out=255. Mirrored window -> gx=-1020, identical outputs.
- Diagonal: p0=p1=p3=0, others 255 -> magnitude=1530, pixel_out=255. With threshold=1530, edge_out=255; with threshold=1531, edge_out=0.
- Protocol checks:
  - start pulses while busy plus window changes during computation -> ignored, result from the latched window only;
  - start in the done cycle -> second done exactly 4 cycles after the first.
- Reset asserted in CALC_Y -> no done pulse, outputs 0. A fresh start after release gives correct results with normal latency.
